piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 129 ++++++++++++
 tb/tb_piso_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out word serializer with valid/ready load, frame strobe,
// optional even parity bit and a configurable idle gap after every frame.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PAR,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               par_q, par_d;
  logic               sout_q, sout_d;
  logic               sframe_q, sframe_d;
  logic               done_q, done_d;

  // Next-state and next-output logic; sout/sframe/done default to idle values.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    par_d    = par_q;
    sout_d   = 1'b0;
    sframe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          shreg_d  = din;
          par_d    = ^din;
          sout_d   = MSB_FIRST ? din[WIDTH-1] : din[0];
          sframe_d = 1'b1;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (PARITY_EN) begin
            sout_d   = par_q;
            sframe_d = 1'b1;
            done_d   = 1'b1;
            state_d  = S_PAR;
          end else begin
            gcnt_d  = GAP_LOAD;
            state_d = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end else begin
          // The bit shown now sits at the output end; present its neighbour next.
          shreg_d  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          sout_d   = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
          sframe_d = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          done_d   = (cnt_q == CNT_W'(1)) && !PARITY_EN;
        end
      end

      S_PAR: begin
        gcnt_d  = GAP_LOAD;
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
      end

      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      par_q    <= 1'b0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      par_q    <= par_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  assign sout      = sout_q;
  assign sframe    = sframe_q;
  assign done      = done_q;
  assign din_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three parameter sets checked every cycle against a
// frame-list model, plus directed literal checks of bit order, parity and timing.
module tb_piso_serializer;

  localparam int N = 3;
  localparam int W = 8;
  localparam int MSB_A[0:N] = '{1, 0, 1, 1};
  localparam int PAR_A[0:N] = '{1, 1, 0, 1};
  localparam int GAP_A[0:N] = '{1, 1, 0, 1};

  logic         Clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din       [N];
  logic         din_valid [N];
  logic         din_ready [N];
  logic         sout      [N];
  logic         sframe    [N];
  logic         done      [N];
  logic         busy      [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .GAP(1)) u0 (
    .Clk(Clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .sout(sout[0]), .sframe(sframe[0]), .done(done[0]), .busy(busy[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .GAP(1)) u1 (
    .Clk(Clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .sout(sout[1]), .sframe(sframe[1]), .done(done[1]), .busy(busy[1]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .GAP(0)) u2 (
    .Clk(Clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .sout(sout[2]), .sframe(sframe[2]), .done(done[2]), .busy(busy[2]));

  typedef struct packed {
    logic s;
    logic f;
    logic d;
  } ent_t;

  // Model: per instance, the list of expected per-cycle outputs of the frame in flight.
  ent_t mframe [0:N][0:15];
  int   mlen   [0:N];
  int   mpos   [0:N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_load(input int i, input logic [W-1:0] word,
                            input int msb, input int par, input int gap);
    int k = 0;
    for (int b = 0; b < W; b++) begin
      mframe[i][k] = '{s: (msb != 0) ? word[W-1-b] : word[b], f: 1'b1,
                       d: (b == W - 1) && (par == 0)};
      k++;
    end
    if (par != 0) begin
      mframe[i][k] = '{s: ^word, f: 1'b1, d: 1'b1};
      k++;
    end
    for (int g = 0; g < gap; g++) begin
      mframe[i][k] = '{s: 1'b0, f: 1'b0, d: 1'b0};
      k++;
    end
    mlen[i] = k;
    mpos[i] = 0;
  endtask

  initial begin
    for (int i = 0; i <= N; i++) begin
      mlen[i] = 0;
      mpos[i] = 0;
    end
  end

  always @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        mlen[i] = 0;
        mpos[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mpos[i] < mlen[i]) mpos[i]++;
        else if (din_valid[i]) model_load(i, din[i], MSB_A[i], PAR_A[i], GAP_A[i]);
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge Clk) begin
    ent_t e;
    logic act;
    for (int i = 0; i < N; i++) begin
      act = (mpos[i] < mlen[i]);
      e   = act ? mframe[i][mpos[i]] : '0;
      check($sformatf("sout[%0d]", i),      32'(sout[i]),      32'(e.s));
      check($sformatf("sframe[%0d]", i),    32'(sframe[i]),    32'(e.f));
      check($sformatf("done[%0d]", i),      32'(done[i]),      32'(e.d));
      check($sformatf("din_ready[%0d]", i), 32'(din_ready[i]), 32'(!act));
      check($sformatf("busy[%0d]", i),      32'(busy[i]),      32'(act));
    end
  end

  logic [8:0]  v0, v1, f2, d0;
  logic [21:0] sf22, so22;
  int          rdy_low;

  initial begin
    for (int i = 0; i < N; i++) begin
      din[i]       = '0;
      din_valid[i] = 1'b0;
    end

    // Pin the model with hand-derived frames.
    model_load(3, 8'hA5, 1, 1, 1);
    v0 = '0;
    for (int b = 0; b < 9; b++) v0 = {v0[7:0], mframe[3][b].s};
    check("model_a5_bits", 32'(v0), 32'h14A);
    check("model_a5_len", 32'(mlen[3]), 32'd10);
    check("model_a5_done", 32'(mframe[3][8].d), 32'd1);
    model_load(3, 8'h07, 0, 1, 1);
    v0 = '0;
    for (int b = 0; b < 9; b++) v0 = {v0[7:0], mframe[3][b].s};
    check("model_07_lsb_bits", 32'(v0), 32'h1C1);

    // Reset held while clocking.
    #1 rst = 1'b0;
    repeat (4) @(negedge Clk);
    check("rst_sout", 32'(sout[0]), 32'd0);
    check("rst_sframe", 32'(sframe[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) din[i] = 8'($urandom);
      @(negedge Clk);
      check("idle_ready", 32'(din_ready[0]), 32'd1);
      check("idle_sframe", 32'(sframe[0]), 32'd0);
    end

    // Single frames on all three instances; u2 gets a second word at once.
    din[0] = 8'hA5; din[1] = 8'h07; din[2] = 8'hFF;
    for (int i = 0; i < N; i++) din_valid[i] = 1'b1;
    @(negedge Clk);
    din_valid[0] = 1'b0; din_valid[1] = 1'b0;
    din[0] = 8'h00; din[1] = 8'hFF; din[2] = 8'h81;
    v0 = '0; v1 = '0; f2 = '0; d0 = '0; rdy_low = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 9) din_valid[2] = 1'b0;
      if (j < 9) begin
        v0 = {v0[7:0], sout[0]};
        v1 = {v1[7:0], sout[1]};
        f2 = {f2[7:0], sframe[2]};
        d0 = {d0[7:0], done[0]};
      end
      if (!din_ready[0]) rdy_low++;
      @(negedge Clk);
    end
    check("a5_bits", 32'(v0), 32'h14A);
    check("07_lsb_bits", 32'(v1), 32'h1C1);
    check("ff_sframe_then_idle", 32'(f2), 32'h1FE);
    check("a5_done_pos", 32'(d0), 32'h001);
    check("a5_ready_low_cycles", 32'(rdy_low), 32'd10);
    repeat (10) @(negedge Clk);

    // Back-to-back frames with din_valid held; din disturbed mid-frame.
    din[0] = 8'h01; din_valid[0] = 1'b1;
    @(negedge Clk);
    sf22 = '0; so22 = '0;
    for (int j = 0; j < 22; j++) begin
      if (j == 0) din[0] = 8'h5A;
      if (j == 5) din[0] = 8'h80;
      if (j == 11) din_valid[0] = 1'b0;
      sf22 = {sf22[20:0], sframe[0]};
      so22 = {so22[20:0], sout[0]};
      @(negedge Clk);
    end
    check("b2b_sframe", 32'(sf22), 32'(22'b1111111110011111111100));
    check("b2b_sout", 32'(so22), 32'(22'b0000000110010000000100));
    repeat (3) @(negedge Clk);

    // Asynchronous reset during data bit 4 aborts the frame.
    din[0] = 8'hA5; din_valid[0] = 1'b1;
    @(negedge Clk);
    din_valid[0] = 1'b0;
    repeat (3) @(negedge Clk);
    check("abort_pre_sframe", 32'(sframe[0]), 32'd1);
    check("abort_pre_busy", 32'(busy[0]), 32'd1);
    check("abort_pre_bit4", 32'(sout[0]), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_sout", 32'(sout[0]), 32'd0);
    check("abort_sframe", 32'(sframe[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_ready", 32'(din_ready[0]), 32'd1);
    repeat (2) @(negedge Clk);
    rst = 1'b1;
    din[0] = 8'h3C; din_valid[0] = 1'b1;
    @(negedge Clk);
    din_valid[0] = 1'b0;
    v0 = '0; d0 = '0;
    for (int j = 0; j < 9; j++) begin
      v0 = {v0[7:0], sout[0]};
      d0 = {d0[7:0], done[0]};
      @(negedge Clk);
    end
    check("3c_bits", 32'(v0), 32'h078);
    check("3c_done_pos", 32'(d0), 32'h001);
    repeat (4) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
